// File: rtl/ddr3_burst_arbiter_if.sv
// DDR3 IP user command/write-data port bundle between the burst arbiter and the memory controller.
// Latency: wires only, no storage.
// Backpressure: app_rdy / app_wdf_rdy from the IP stall the arbiter's command and data strobes.
interface ddr3_burst_arbiter_if #(
   parameter int ADDR_W = 29
);
   logic              app_en;
   logic [2:0]        app_cmd;
   logic [ADDR_W-1:0] app_addr;
   logic              app_wdf_wren;
   logic              app_wdf_end;
   logic              app_rdy;
   logic              app_wdf_rdy;
   logic              app_rd_data_valid;

   modport master (
      output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
      input  app_rdy, app_wdf_rdy, app_rd_data_valid
   );

   modport slave (
      input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
      output app_rdy, app_wdf_rdy, app_rd_data_valid
   );
endinterface

// File: rtl/ddr3_burst_arbiter.sv
// Round-robin whole-burst arbiter of the DDR3 user port between a write FIFO and a read FIFO,
// with wrapping per-port address windows. Grant decided in 1 IDLE cycle, commands start next cycle.
// Backpressure: strobes follow app_rdy (& app_wdf_rdy for writes). Optional DDR3_ARB_RD_DRAIN_EN.
module ddr3_burst_arbiter #(
   parameter int ADDR_W    = 29,
   parameter int ADDR_STEP = 8,
   parameter int LEN_W     = 8,
   parameter int OUTSTD_W  = 9
) (
   input  logic              ui_clk,
   input  logic              ddr_rst,
   input  logic              init_calib_complete,
   input  logic              wr_req,
   input  logic              rd_req,
   input  logic              wr_load,
   input  logic              rd_load,
   input  logic [ADDR_W-1:0] app_addr_wr_min,
   input  logic [ADDR_W-1:0] app_addr_wr_max,
   input  logic [ADDR_W-1:0] app_addr_rd_min,
   input  logic [ADDR_W-1:0] app_addr_rd_max,
   input  logic [LEN_W-1:0]  wr_bust_len,
   input  logic [LEN_W-1:0]  rd_bust_len,
   ddr3_burst_arbiter_if.master app,
   output logic              wfifo_rden,
   output logic              rfifo_wren,
   output logic              wr_grant,
   output logic              rd_grant
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WR_BURST = 2'd1;
   localparam logic [1:0] RD_BURST = 2'd2;
   localparam logic [1:0] RD_DRAIN = 2'd3;

   logic [1:0]          state;
   logic [LEN_W-1:0]    beat_cnt;
   logic [LEN_W-1:0]    beat_len;
   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]   rd_ptr;
   logic [ADDR_W-1:0]   addr_hold;
   logic [2:0]          cmd_hold;
   logic                last_wr;
   logic                wr_load_q;
   logic                rd_load_q;
   logic                wr_pend;
   logic                rd_pend;
   logic                wr_edge;
   logic                rd_edge;
   logic                wr_stb;
   logic                rd_stb;
   logic                last_beat;
   logic [ADDR_W:0]     wr_sum;
   logic [ADDR_W:0]     rd_sum;
   logic [ADDR_W-1:0]   wr_next;
   logic [ADDR_W-1:0]   rd_next;
   logic [OUTSTD_W-1:0] outstd;

   // Beat strobes, load edges and wrapped next pointers (sum kept one bit wider so max near the top can't overflow)
   always_comb begin
      wr_stb    = (state == WR_BURST) && init_calib_complete && app.app_rdy && app.app_wdf_rdy;
      rd_stb    = (state == RD_BURST) && init_calib_complete && app.app_rdy;
      last_beat = (beat_cnt == beat_len - LEN_W'(1));
      wr_edge   = wr_load & ~wr_load_q;
      rd_edge   = rd_load & ~rd_load_q;
      wr_sum    = {1'b0, wr_ptr} + (ADDR_W+1)'(ADDR_STEP);
      rd_sum    = {1'b0, rd_ptr} + (ADDR_W+1)'(ADDR_STEP);
      wr_next   = (wr_sum >= {1'b0, app_addr_wr_max}) ? app_addr_wr_min : wr_sum[ADDR_W-1:0];
      rd_next   = (rd_sum >= {1'b0, app_addr_rd_max}) ? app_addr_rd_min : rd_sum[ADDR_W-1:0];
   end

   // Port outputs: live pointer/command during a burst, otherwise the last value driven
   always_comb begin
      app.app_en       = wr_stb | rd_stb;
      app.app_wdf_wren = wr_stb;
      app.app_wdf_end  = wr_stb;
      wfifo_rden       = wr_stb;
      rfifo_wren       = app.app_rd_data_valid;
      wr_grant         = (state == WR_BURST);
      rd_grant         = (state == RD_BURST) || (state == RD_DRAIN);
      app.app_cmd      = cmd_hold;
      app.app_addr     = addr_hold;
      if (state == WR_BURST) begin
         app.app_cmd  = 3'd0;
         app.app_addr = wr_ptr;
      end else if (state == RD_BURST) begin
         app.app_cmd  = 3'd1;
         app.app_addr = rd_ptr;
      end
   end

`ifdef DDR3_ARB_RD_DRAIN_EN
   // Reads issued but not yet returned; a simultaneous issue and return cancel out
   always_ff @(posedge ui_clk or posedge ddr_rst) begin
      if (ddr_rst) begin
         outstd <= '0;
      end else begin
         case ({rd_stb, app.app_rd_data_valid})
            2'b10:   outstd <= outstd + OUTSTD_W'(1);
            2'b01:   outstd <= outstd - OUTSTD_W'(1);
            default: outstd <= outstd;
         endcase
      end
   end
`else
   // Without drain tracking nothing is ever considered outstanding
   always_comb outstd = '0;
`endif

   // Grant FSM, beat counting, pointer advance/restart and held command/address
   always_ff @(posedge ui_clk or posedge ddr_rst) begin
      if (ddr_rst) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         beat_len  <= '0;
         wr_ptr    <= app_addr_wr_min;
         rd_ptr    <= app_addr_rd_min;
         addr_hold <= '0;
         cmd_hold  <= '0;
         last_wr   <= 1'b0;
         wr_load_q <= 1'b0;
         rd_load_q <= 1'b0;
         wr_pend   <= 1'b0;
         rd_pend   <= 1'b0;
      end else begin
         wr_load_q <= wr_load;
         rd_load_q <= rd_load;
         // a load edge is remembered until the next IDLE cycle, where it is applied below
         wr_pend   <= wr_pend | wr_edge;
         rd_pend   <= rd_pend | rd_edge;
         if (state == WR_BURST || state == RD_BURST) begin
            addr_hold <= app.app_addr;
            cmd_hold  <= app.app_cmd;
         end
         case (state)
            IDLE: begin
               if (wr_pend || wr_edge) begin
                  wr_ptr  <= app_addr_wr_min;
                  wr_pend <= 1'b0;
               end
               if (rd_pend || rd_edge) begin
                  rd_ptr  <= app_addr_rd_min;
                  rd_pend <= 1'b0;
               end
               beat_cnt <= '0;
               if (init_calib_complete) begin
                  // on a tie the port that did not go last wins
                  if (wr_req && (!rd_req || !last_wr)) begin
                     state    <= WR_BURST;
                     beat_len <= (wr_bust_len == '0) ? LEN_W'(1) : wr_bust_len;
                  end else if (rd_req) begin
                     state    <= RD_BURST;
                     beat_len <= (rd_bust_len == '0) ? LEN_W'(1) : rd_bust_len;
                  end
               end
            end
            WR_BURST: begin
               if (!init_calib_complete) begin
                  state <= IDLE;
               end else if (wr_stb) begin
                  wr_ptr   <= wr_next;
                  beat_cnt <= beat_cnt + LEN_W'(1);
                  if (last_beat) begin
                     state   <= IDLE;
                     last_wr <= 1'b1;
                  end
               end
            end
            RD_BURST: begin
               if (!init_calib_complete) begin
                  state <= IDLE;
               end else if (rd_stb) begin
                  rd_ptr   <= rd_next;
                  beat_cnt <= beat_cnt + LEN_W'(1);
                  if (last_beat) begin
`ifdef DDR3_ARB_RD_DRAIN_EN
                     state   <= RD_DRAIN;
`else
                     state   <= IDLE;
`endif
                     last_wr <= 1'b0;
                  end
               end
            end
            RD_DRAIN: begin
               // hold the read grant until every issued read has returned its data
               if (!init_calib_complete || outstd == '0) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr3_burst_arbiter.sv
// Directed bench for ddr3_burst_arbiter: per-cycle vector table plus hand sequences.
// Latency: inputs driven on the falling edge, outputs compared 1 ns later.
// Backpressure: app_rdy / app_wdf_rdy stalls are part of the vector table.
module tb_ddr3_burst_arbiter;

   localparam int ADDR_W = 29;
   localparam int LEN_W  = 8;
   localparam int NV     = 46;

   logic              ui_clk = 1'b0;
   logic              ddr_rst;
   logic              init_calib_complete;
   logic              wr_req, rd_req, wr_load, rd_load;
   logic [ADDR_W-1:0] app_addr_wr_min, app_addr_wr_max, app_addr_rd_min, app_addr_rd_max;
   logic [LEN_W-1:0]  wr_bust_len, rd_bust_len;
   logic              wfifo_rden, rfifo_wren, wr_grant, rd_grant;

   int checks   = 0;
   int failures = 0;

   ddr3_burst_arbiter_if #(.ADDR_W(ADDR_W)) app_bus ();

   ddr3_burst_arbiter #(.ADDR_W(ADDR_W), .ADDR_STEP(8), .LEN_W(LEN_W), .OUTSTD_W(9)) dut (
      .ui_clk              (ui_clk),
      .ddr_rst             (ddr_rst),
      .init_calib_complete (init_calib_complete),
      .wr_req              (wr_req),
      .rd_req              (rd_req),
      .wr_load             (wr_load),
      .rd_load             (rd_load),
      .app_addr_wr_min     (app_addr_wr_min),
      .app_addr_wr_max     (app_addr_wr_max),
      .app_addr_rd_min     (app_addr_rd_min),
      .app_addr_rd_max     (app_addr_rd_max),
      .wr_bust_len         (wr_bust_len),
      .rd_bust_len         (rd_bust_len),
      .app                 (app_bus),
      .wfifo_rden          (wfifo_rden),
      .rfifo_wren          (rfifo_wren),
      .wr_grant            (wr_grant),
      .rd_grant            (rd_grant)
   );

   always #5 ui_clk = ~ui_clk;

   typedef struct {
      bit wr, rd, rdy, wdf, wl, rv, cal;
      int wlen, rlen;
      bit en, wren;
      int cmd;
      int addr;
      bit wg, rg;
   } vec_t;

   vec_t tv [NV];

   function automatic vec_t mk(input bit wr, rd, rdy, wdf, wl, rv, cal, input int wlen, rlen,
                               input bit en, wren, input int cmd, addr, input bit wg, rg);
      vec_t v;
      v.wr = wr; v.rd = rd; v.rdy = rdy; v.wdf = wdf; v.wl = wl; v.rv = rv; v.cal = cal;
      v.wlen = wlen; v.rlen = rlen; v.en = en; v.wren = wren; v.cmd = cmd; v.addr = addr;
      v.wg = wg; v.rg = rg;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %0d want %0d", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input bit en, wren, input int cmd, addr, input bit wg, rg);
      chk("app_en",       idx, 32'(app_bus.app_en),       32'(en));
      chk("app_wdf_wren", idx, 32'(app_bus.app_wdf_wren), 32'(wren));
      chk("app_wdf_end",  idx, 32'(app_bus.app_wdf_end),  32'(wren));
      chk("wfifo_rden",   idx, 32'(wfifo_rden),           32'(wren));
      chk("app_cmd",      idx, 32'(app_bus.app_cmd),      32'(cmd));
      chk("app_addr",     idx, 32'(app_bus.app_addr),     32'(addr));
      chk("wr_grant",     idx, 32'(wr_grant),             32'(wg));
      chk("rd_grant",     idx, 32'(rd_grant),             32'(rg));
   endtask

   initial begin
      // wr window [0,64), rd window [4096,4160)
      //           wr rd rdy wdf wl rv cal wlen rlen  en wren cmd addr  wg rg
      tv[0]  = mk(1, 0, 1, 1, 0, 0, 1, 4, 2,  0, 0, 0, 0,    0, 0);
      tv[1]  = mk(0, 0, 1, 1, 0, 0, 1, 4, 2,  1, 1, 0, 0,    1, 0);
      tv[2]  = mk(0, 0, 1, 1, 0, 0, 1, 4, 2,  1, 1, 0, 8,    1, 0);
      tv[3]  = mk(0, 0, 1, 1, 0, 0, 1, 4, 2,  1, 1, 0, 16,   1, 0);
      tv[4]  = mk(0, 0, 1, 1, 0, 0, 1, 4, 2,  1, 1, 0, 24,   1, 0);
      tv[5]  = mk(1, 0, 1, 1, 0, 0, 1, 3, 2,  0, 0, 0, 24,   0, 0);
      tv[6]  = mk(0, 0, 1, 1, 0, 0, 1, 3, 2,  1, 1, 0, 32,   1, 0);
      tv[7]  = mk(0, 0, 1, 1, 0, 0, 1, 3, 2,  1, 1, 0, 40,   1, 0);
      tv[8]  = mk(0, 0, 1, 1, 0, 0, 1, 3, 2,  1, 1, 0, 48,   1, 0);
      tv[9]  = mk(1, 0, 1, 1, 0, 0, 1, 2, 2,  0, 0, 0, 48,   0, 0);
      tv[10] = mk(0, 0, 1, 1, 0, 0, 1, 2, 2,  1, 1, 0, 56,   1, 0);
      tv[11] = mk(0, 0, 1, 1, 0, 0, 1, 2, 2,  1, 1, 0, 0,    1, 0);
      tv[12] = mk(1, 1, 1, 1, 0, 0, 1, 2, 2,  0, 0, 0, 0,    0, 0);
      tv[13] = mk(1, 1, 1, 1, 0, 0, 1, 2, 2,  1, 0, 1, 4096, 0, 1);
      tv[14] = mk(1, 1, 1, 1, 0, 0, 1, 2, 2,  1, 0, 1, 4104, 0, 1);
      tv[15] = mk(1, 1, 1, 1, 0, 1, 1, 2, 2,  0, 0, 1, 4104, 0, 0);
      tv[16] = mk(1, 1, 1, 1, 0, 0, 1, 2, 2,  1, 1, 0, 8,    1, 0);
      tv[17] = mk(1, 1, 1, 1, 0, 0, 1, 2, 2,  1, 1, 0, 16,   1, 0);
      tv[18] = mk(1, 1, 1, 1, 0, 0, 1, 2, 2,  0, 0, 0, 16,   0, 0);
      tv[19] = mk(1, 1, 1, 1, 0, 0, 1, 2, 2,  1, 0, 1, 4112, 0, 1);
      tv[20] = mk(1, 1, 1, 1, 0, 0, 1, 2, 2,  1, 0, 1, 4120, 0, 1);
      tv[21] = mk(0, 0, 1, 1, 0, 1, 1, 2, 2,  0, 0, 1, 4120, 0, 0);
      tv[22] = mk(1, 0, 1, 1, 0, 0, 1, 4, 2,  0, 0, 1, 4120, 0, 0);
      tv[23] = mk(0, 0, 1, 1, 0, 0, 1, 4, 2,  1, 1, 0, 24,   1, 0);
      tv[24] = mk(0, 0, 0, 1, 0, 0, 1, 4, 2,  0, 0, 0, 32,   1, 0);
      tv[25] = mk(0, 0, 1, 0, 0, 0, 1, 4, 2,  0, 0, 0, 32,   1, 0);
      tv[26] = mk(0, 0, 0, 1, 0, 0, 1, 4, 2,  0, 0, 0, 32,   1, 0);
      tv[27] = mk(0, 0, 1, 1, 0, 0, 1, 4, 2,  1, 1, 0, 32,   1, 0);
      tv[28] = mk(0, 0, 1, 1, 0, 0, 1, 4, 2,  1, 1, 0, 40,   1, 0);
      tv[29] = mk(0, 0, 1, 1, 0, 0, 1, 4, 2,  1, 1, 0, 48,   1, 0);
      tv[30] = mk(1, 0, 1, 1, 0, 0, 1, 4, 2,  0, 0, 0, 48,   0, 0);
      tv[31] = mk(0, 0, 1, 1, 0, 0, 1, 4, 2,  1, 1, 0, 56,   1, 0);
      tv[32] = mk(0, 0, 1, 1, 1, 0, 1, 4, 2,  1, 1, 0, 0,    1, 0);
      tv[33] = mk(0, 0, 1, 1, 1, 0, 1, 4, 2,  1, 1, 0, 8,    1, 0);
      tv[34] = mk(0, 0, 1, 1, 1, 0, 1, 4, 2,  1, 1, 0, 16,   1, 0);
      tv[35] = mk(1, 0, 1, 1, 0, 0, 1, 2, 2,  0, 0, 0, 16,   0, 0);
      tv[36] = mk(0, 0, 1, 1, 0, 0, 1, 2, 2,  1, 1, 0, 0,    1, 0);
      tv[37] = mk(0, 0, 1, 1, 0, 0, 1, 2, 2,  1, 1, 0, 8,    1, 0);
      tv[38] = mk(0, 1, 1, 1, 0, 0, 1, 2, 4,  0, 0, 0, 8,    0, 0);
      tv[39] = mk(0, 0, 1, 1, 0, 0, 1, 2, 4,  1, 0, 1, 4128, 0, 1);
      tv[40] = mk(0, 0, 1, 1, 0, 0, 1, 2, 4,  1, 0, 1, 4136, 0, 1);
      tv[41] = mk(0, 0, 1, 1, 0, 0, 0, 2, 4,  0, 0, 1, 4144, 0, 1);
      tv[42] = mk(0, 0, 1, 1, 0, 0, 0, 2, 4,  0, 0, 1, 4144, 0, 0);
      tv[43] = mk(0, 1, 1, 1, 0, 0, 1, 2, 0,  0, 0, 1, 4144, 0, 0);
      tv[44] = mk(0, 0, 1, 1, 0, 0, 1, 2, 0,  1, 0, 1, 4144, 0, 1);
      tv[45] = mk(0, 0, 1, 1, 0, 0, 1, 2, 0,  0, 0, 1, 4144, 0, 0);

      ddr_rst = 1'b1;
      init_calib_complete = 1'b1;
      wr_req = 1'b0; rd_req = 1'b0; wr_load = 1'b0; rd_load = 1'b0;
      app_addr_wr_min = 29'd0;    app_addr_wr_max = 29'd64;
      app_addr_rd_min = 29'd4096; app_addr_rd_max = 29'd4160;
      wr_bust_len = 8'd4; rd_bust_len = 8'd2;
      app_bus.app_rdy = 1'b1; app_bus.app_wdf_rdy = 1'b1; app_bus.app_rd_data_valid = 1'b0;

      // reset state
      repeat (2) @(negedge ui_clk);
      #1;
      chk_all(-1, 0, 0, 0, 0, 0, 0);
      chk("rfifo_wren", -1, 32'(rfifo_wren), 32'd0);

      // per-cycle vector table
      @(negedge ui_clk);
      ddr_rst = 1'b0;
      for (int i = 0; i < NV; i++) begin
         @(negedge ui_clk);
         wr_req = tv[i].wr; rd_req = tv[i].rd; wr_load = tv[i].wl;
         init_calib_complete = tv[i].cal;
         app_bus.app_rdy = tv[i].rdy; app_bus.app_wdf_rdy = tv[i].wdf;
         app_bus.app_rd_data_valid = tv[i].rv;
         wr_bust_len = LEN_W'(tv[i].wlen); rd_bust_len = LEN_W'(tv[i].rlen);
         #1;
         chk_all(i, tv[i].en, tv[i].wren, tv[i].cmd, tv[i].addr, tv[i].wg, tv[i].rg);
         chk("rfifo_wren", i, 32'(rfifo_wren), 32'(tv[i].rv));
      end

      // rd_load edge in the same IDLE cycle as a grant: restart still applied (rd_ptr was 4152)
      @(negedge ui_clk);
      rd_req = 1'b1; rd_bust_len = 8'd1; rd_load = 1'b1;
      @(negedge ui_clk);
      rd_req = 1'b0; rd_load = 1'b0;
      #1;
      chk_all(100, 1, 0, 1, 4096, 0, 1);

      // async reset mid write burst (wr_ptr was 16)
      @(negedge ui_clk);
      wr_req = 1'b1; wr_bust_len = 8'd4;
      #1;
      chk("idle_wr_grant", 101, 32'(wr_grant), 32'd0);
      @(negedge ui_clk);
      wr_req = 1'b0;
      #1;
      chk_all(102, 1, 1, 0, 16, 1, 0);
      @(negedge ui_clk);
      #1;
      chk_all(103, 1, 1, 0, 24, 1, 0);
      #2 ddr_rst = 1'b1;
      #1;
      chk_all(104, 0, 0, 0, 0, 0, 0);
      @(negedge ui_clk);
      ddr_rst = 1'b0; wr_req = 1'b1; wr_bust_len = 8'd2;
      @(negedge ui_clk);
      wr_req = 1'b0;
      #1;
      chk_all(105, 1, 1, 0, 0, 1, 0);
      @(negedge ui_clk);
      #1;
      chk_all(106, 1, 1, 0, 8, 1, 0);
      @(negedge ui_clk);
      #1;
      chk_all(107, 0, 0, 0, 8, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
